// File: rtl/execute_alu_if.sv
// Dispatch/result bus between the reservation station and the execute ALU.
// The RS side drives dispatch (master); the ALU drives busy and result broadcast (slave).
interface execute_alu_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6
);
    logic              rs_to_alu_ready;
    logic [OP_W-1:0]   rs_to_alu_op;
    logic [DATA_W-1:0] rs_to_alu_rs1;
    logic [DATA_W-1:0] rs_to_alu_rs2;
    logic [DATA_W-1:0] rs_to_alu_imm;
    logic [DATA_W-1:0] rs_to_alu_PC;
    logic [ROB_W-1:0]  rs_to_alu_rob_index;

    logic              alu_busy;
    logic              alu_to_rs_ready;
    logic [DATA_W-1:0] alu_to_rs_result;
    logic [ROB_W-1:0]  alu_to_rs_rob_index;
    logic              alu_to_rob_jump;
    logic [DATA_W-1:0] alu_to_rob_target;

    modport master (
        output rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
               rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index,
        input  alu_busy, alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index,
               alu_to_rob_jump, alu_to_rob_target
    );

    modport slave (
        input  rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
               rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index,
        output alu_busy, alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index,
               alu_to_rob_jump, alu_to_rob_target
    );
endinterface

// File: rtl/execute_alu.sv
// Execute unit: single-cycle integer/branch ops with registered result broadcast.
// Define ALU_MUL_EN to build the 32-step shift-add multiplier (ops 48-51) with busy back-pressure.
module execute_alu #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6
) (
    input logic          clk_in,
    input logic          rst_in,
    input logic          rdy_in,
    input logic          clr_in,
    execute_alu_if.slave bus
);
    typedef logic [DATA_W-1:0] data_t;

    function automatic data_t alu_fn(input logic [3:0] fn, input data_t a, input data_t b);
        data_t r;
        r = '0;
        case (fn)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a << b[4:0];
            4'd3:    r = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            4'd4:    r = {{(DATA_W-1){1'b0}}, a < b};
            4'd5:    r = a ^ b;
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $signed(a) >>> b[4:0];
            4'd8:    r = a | b;
            4'd9:    r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    data_t            rs1, rs2, imm, pc, pc4;
    data_t            c_result, c_target;
    logic             c_jump, br_taken;
    logic             accept, is_mul, mul_done;
    data_t            mul_word, mul_pc4;
    logic [ROB_W-1:0] mul_rob;

    logic             out_ready, out_jump;
    data_t            out_result, out_target;
    logic [ROB_W-1:0] out_rob;

    assign op     = bus.rs_to_alu_op;
    assign rob    = bus.rs_to_alu_rob_index;
    assign rs1    = bus.rs_to_alu_rs1;
    assign rs2    = bus.rs_to_alu_rs2;
    assign imm    = bus.rs_to_alu_imm;
    assign pc     = bus.rs_to_alu_PC;
    assign pc4    = pc + data_t'(4);
    assign accept = bus.rs_to_alu_ready && !bus.alu_busy;

    // Single-cycle datapath; anything not decoded falls through to result 0, target PC+4
    always_comb begin
        c_result = '0;
        c_jump   = 1'b0;
        c_target = pc4;
        br_taken = 1'b0;
        case (op)
            6'd32: c_result = imm;
            6'd33: c_result = pc + imm;
            6'd34: begin
                c_result = pc4;
                c_target = pc + imm;
                c_jump   = 1'b1;
            end
            6'd35: begin
                c_result = pc4;
                c_target = (rs1 + imm) & {{(DATA_W-1){1'b1}}, 1'b0};
                c_jump   = 1'b1;
            end
            6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45: begin
                case (op[2:0])
                    3'd0:    br_taken = (rs1 == rs2);
                    3'd1:    br_taken = (rs1 != rs2);
                    3'd2:    br_taken = ($signed(rs1) < $signed(rs2));
                    3'd3:    br_taken = ($signed(rs1) >= $signed(rs2));
                    3'd4:    br_taken = (rs1 < rs2);
                    3'd5:    br_taken = (rs1 >= rs2);
                    default: br_taken = 1'b0;
                endcase
                c_jump   = br_taken;
                c_target = br_taken ? (pc + imm) : pc4;
            end
            default: begin
                if (op[5:4] == 2'b00 && op[3:0] <= 4'd9)
                    c_result = alu_fn(op[3:0], rs1, rs2);
                else if (op[5:4] == 2'b01 && op[3:0] <= 4'd9 && op[3:0] != 4'd1)
                    c_result = alu_fn(op[3:0], rs1, imm);
            end
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int ACC_W = 2 * DATA_W;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [4:0]       counter;
    logic [ACC_W-1:0] acc, a_sh, product;
    data_t            b_sh, a_mag, b_mag;
    logic             neg_flag, hi_sel, a_signed, b_signed;
    logic [ROB_W-1:0] mul_rob_q;
    data_t            mul_pc4_q;

    // Multiply on magnitudes; MULH signs both operands, MULHSU only rs1
    assign is_mul   = (op[5:2] == 4'b1100);
    assign a_signed = (op[1:0] == 2'd1) || (op[1:0] == 2'd2);
    assign b_signed = (op[1:0] == 2'd1);
    assign a_mag    = (a_signed && rs1[DATA_W-1]) ? -rs1 : rs1;
    assign b_mag    = (b_signed && rs2[DATA_W-1]) ? -rs2 : rs2;
    assign product  = neg_flag ? -acc : acc;
    assign mul_word = hi_sel ? product[ACC_W-1:DATA_W] : product[DATA_W-1:0];
    assign mul_done = (state == ST_DONE);
    assign mul_rob  = mul_rob_q;
    assign mul_pc4  = mul_pc4_q;
    assign bus.alu_busy = (state != ST_IDLE);

    // Bit 0 is folded in on acceptance, so 31 RUN cycles cover bits 1..31
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            counter   <= '0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            neg_flag  <= 1'b0;
            hi_sel    <= 1'b0;
            mul_rob_q <= '0;
            mul_pc4_q <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                state   <= ST_IDLE;
                counter <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept && is_mul) begin
                            state     <= ST_RUN;
                            counter   <= '0;
                            acc       <= b_mag[0] ? {{DATA_W{1'b0}}, a_mag} : '0;
                            a_sh      <= {{(DATA_W-1){1'b0}}, a_mag, 1'b0};
                            b_sh      <= b_mag >> 1;
                            neg_flag  <= (a_signed & rs1[DATA_W-1]) ^ (b_signed & rs2[DATA_W-1]);
                            hi_sel    <= (op[1:0] != 2'd0);
                            mul_rob_q <= rob;
                            mul_pc4_q <= pc4;
                        end
                    end
                    ST_RUN: begin
                        acc     <= acc + (b_sh[0] ? a_sh : '0);
                        a_sh    <= a_sh << 1;
                        b_sh    <= b_sh >> 1;
                        counter <= counter + 5'd1;
                        if (counter == 5'd30)
                            state <= ST_DONE;
                    end
                    ST_DONE: begin
                        state   <= ST_IDLE;
                        counter <= '0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
`else
    assign is_mul       = 1'b0;
    assign mul_done     = 1'b0;
    assign mul_word     = '0;
    assign mul_rob      = '0;
    assign mul_pc4      = '0;
    assign bus.alu_busy = 1'b0;
`endif

    // Result broadcast register; flush wins over both the mul result and a new dispatch
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_ready  <= 1'b0;
            out_result <= '0;
            out_rob    <= '0;
            out_jump   <= 1'b0;
            out_target <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                out_ready <= 1'b0;
            end else if (mul_done) begin
                out_ready  <= 1'b1;
                out_result <= mul_word;
                out_rob    <= mul_rob;
                out_jump   <= 1'b0;
                out_target <= mul_pc4;
            end else if (accept && !is_mul) begin
                out_ready  <= 1'b1;
                out_result <= c_result;
                out_rob    <= rob;
                out_jump   <= c_jump;
                out_target <= c_target;
            end else begin
                out_ready <= 1'b0;
            end
        end
    end

    assign bus.alu_to_rs_ready     = out_ready;
    assign bus.alu_to_rs_result    = out_result;
    assign bus.alu_to_rs_rob_index = out_rob;
    assign bus.alu_to_rob_jump     = out_jump;
    assign bus.alu_to_rob_target   = out_target;
endmodule

// File: tb/tb_execute_alu.sv
// Directed testbench for execute_alu; multiply, flush and stall scenarios run when ALU_MUL_EN is defined.
module tb_execute_alu;
    logic clk_in = 1'b0;
    logic rst_in, rdy_in, clr_in;
    int   assertions = 0;
    int   failures   = 0;
    int   cycles, busy_cycles, pulses;

    execute_alu_if bus ();

    execute_alu dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr_in (clr_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] result, input logic [3:0] rob,
                               input logic jump, input logic [31:0] target);
        checkOutput({tag, "_ready"}, {31'd0, bus.alu_to_rs_ready}, 32'd1);
        checkOutput({tag, "_result"}, bus.alu_to_rs_result, result);
        checkOutput({tag, "_rob"}, {28'd0, bus.alu_to_rs_rob_index}, {28'd0, rob});
        checkOutput({tag, "_jump"}, {31'd0, bus.alu_to_rob_jump}, {31'd0, jump});
        checkOutput({tag, "_target"}, bus.alu_to_rob_target, target);
    endtask

    // Drives one dispatch pulse; returns 1ns after the accepting edge
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        @(negedge clk_in);
        checkOutput("dispatch_not_busy", {31'd0, bus.alu_busy}, 32'd0);
        bus.rs_to_alu_ready     = 1'b1;
        bus.rs_to_alu_op        = op;
        bus.rs_to_alu_rs1       = rs1;
        bus.rs_to_alu_rs2       = rs2;
        bus.rs_to_alu_imm       = imm;
        bus.rs_to_alu_PC        = pc;
        bus.rs_to_alu_rob_index = rob;
        @(posedge clk_in);
        #1;
        bus.rs_to_alu_ready = 1'b0;
    endtask

    task automatic waitResult(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        do begin
            @(posedge clk_in);
            #1;
            n++;
            if (bus.alu_busy === 1'b1) busy_n++;
        end while (bus.alu_to_rs_ready !== 1'b1 && n < 80);
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        clr_in = 1'b0;
        bus.rs_to_alu_ready     = 1'b0;
        bus.rs_to_alu_op        = '0;
        bus.rs_to_alu_rs1       = '0;
        bus.rs_to_alu_rs2       = '0;
        bus.rs_to_alu_imm       = '0;
        bus.rs_to_alu_PC        = '0;
        bus.rs_to_alu_rob_index = '0;

        #12;
        checkOutput("reset_ready", {31'd0, bus.alu_to_rs_ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, bus.alu_busy}, 32'd0);
        checkOutput("reset_result", bus.alu_to_rs_result, 32'd0);
        checkOutput("reset_target", bus.alu_to_rob_target, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        applyStimulus(6'd0, 32'd5, 32'd7, 32'd0, 32'h40, 4'd3);
        checkResult("add", 32'd12, 4'd3, 1'b0, 32'h44);

`ifdef ALU_MUL_EN
        applyStimulus(6'd48, 32'd9, 32'd9, 32'd0, 32'h80, 4'd6);
        checkOutput("mul_start_busy", {31'd0, bus.alu_busy}, 32'd1);
`else
        applyStimulus(6'd0, 32'd1, 32'd1, 32'd0, 32'h80, 4'd6);
`endif
        repeat (5) @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("async_reset_ready", {31'd0, bus.alu_to_rs_ready}, 32'd0);
        checkOutput("async_reset_busy", {31'd0, bus.alu_busy}, 32'd0);
        checkOutput("async_reset_result", bus.alu_to_rs_result, 32'd0);
        checkOutput("async_reset_rob", {28'd0, bus.alu_to_rs_rob_index}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        applyStimulus(6'd0, 32'd5, 32'd7, 32'd0, 32'h40, 4'd3);
        checkResult("add_after_reset", 32'd12, 4'd3, 1'b0, 32'h44);
        @(posedge clk_in);
        #1;
        checkOutput("add_pulse_width", {31'd0, bus.alu_to_rs_ready}, 32'd0);

        applyStimulus(6'd1, 32'd3, 32'd5, 32'd0, 32'h10, 4'd1);
        checkResult("sub", 32'hFFFF_FFFE, 4'd1, 1'b0, 32'h14);
        applyStimulus(6'd2, 32'd1, 32'd33, 32'd0, 32'h10, 4'd2);
        checkResult("sll_shamt_wrap", 32'd2, 4'd2, 1'b0, 32'h14);
        applyStimulus(6'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 4'd4);
        checkResult("slt", 32'd1, 4'd4, 1'b0, 32'h14);
        applyStimulus(6'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h10, 4'd5);
        checkResult("sltu", 32'd0, 4'd5, 1'b0, 32'h14);
        applyStimulus(6'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h10, 4'd6);
        checkResult("xor", 32'h0FF0_0FF0, 4'd6, 1'b0, 32'h14);
        applyStimulus(6'd6, 32'h8000_0000, 32'd31, 32'd0, 32'h10, 4'd7);
        checkResult("srl", 32'd1, 4'd7, 1'b0, 32'h14);
        applyStimulus(6'd16, 32'd10, 32'd99, 32'hFFFF_FFFD, 32'h10, 4'd8);
        checkResult("addi", 32'd7, 4'd8, 1'b0, 32'h14);
        applyStimulus(6'd23, 32'h8000_0000, 32'd0, 32'd4, 32'h10, 4'd9);
        checkResult("srai", 32'hF800_0000, 4'd9, 1'b0, 32'h14);
        applyStimulus(6'd17, 32'd10, 32'd1, 32'd3, 32'h10, 4'd10);
        checkResult("op17_undefined", 32'd0, 4'd10, 1'b0, 32'h14);
        applyStimulus(6'd12, 32'd10, 32'd1, 32'd3, 32'h10, 4'd11);
        checkResult("op12_undefined", 32'd0, 4'd11, 1'b0, 32'h14);
        applyStimulus(6'd32, 32'd0, 32'd0, 32'h1234_5000, 32'h10, 4'd12);
        checkResult("lui", 32'h1234_5000, 4'd12, 1'b0, 32'h14);
        applyStimulus(6'd33, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd13);
        checkResult("auipc", 32'h3000, 4'd13, 1'b0, 32'h1004);
        applyStimulus(6'd34, 32'd0, 32'd0, 32'h40, 32'h300, 4'd14);
        checkResult("jal", 32'h304, 4'd14, 1'b1, 32'h340);
        applyStimulus(6'd35, 32'h1001, 32'd0, 32'd4, 32'h200, 4'd15);
        checkResult("jalr", 32'h204, 4'd15, 1'b1, 32'h1004);
        applyStimulus(6'd42, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd1);
        checkResult("blt", 32'd0, 4'd1, 1'b1, 32'h120);
        applyStimulus(6'd44, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd2);
        checkResult("bltu", 32'd0, 4'd2, 1'b0, 32'h104);
        applyStimulus(6'd40, 32'd7, 32'd7, 32'h20, 32'h100, 4'd3);
        checkResult("beq", 32'd0, 4'd3, 1'b1, 32'h120);
        applyStimulus(6'd45, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h100, 4'd4);
        checkResult("bgeu", 32'd0, 4'd4, 1'b0, 32'h104);

`ifdef ALU_MUL_EN
        applyStimulus(6'd49, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'h500, 4'd5);
        checkOutput("mulh_busy_first", {31'd0, bus.alu_busy}, 32'd1);
        checkOutput("mulh_no_early_ready", {31'd0, bus.alu_to_rs_ready}, 32'd0);
        waitResult(cycles, busy_cycles);
        checkOutput("mulh_latency", cycles, 32'd32);
        checkOutput("mulh_busy_cycles", busy_cycles, 32'd31);
        checkOutput("mulh_busy_low", {31'd0, bus.alu_busy}, 32'd0);
        checkResult("mulh", 32'hFFFF_FFFF, 4'd5, 1'b0, 32'h504);

        applyStimulus(6'd48, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'h600, 4'd6);
        waitResult(cycles, busy_cycles);
        checkOutput("mul_latency", cycles, 32'd32);
        checkResult("mul", 32'hFFFF_FFFA, 4'd6, 1'b0, 32'h604);
        applyStimulus(6'd0, 32'd100, 32'd23, 32'd0, 32'h700, 4'd7);
        checkResult("add_after_mul", 32'd123, 4'd7, 1'b0, 32'h704);

        applyStimulus(6'd51, 32'd2, 32'd2, 32'd0, 32'h800, 4'd8);
        repeat (9) @(posedge clk_in);
        @(negedge clk_in);
        clr_in = 1'b1;
        bus.rs_to_alu_ready = 1'b1;
        bus.rs_to_alu_op    = 6'd0;
        @(posedge clk_in);
        #1;
        clr_in = 1'b0;
        bus.rs_to_alu_ready = 1'b0;
        checkOutput("flush_busy", {31'd0, bus.alu_busy}, 32'd0);
        checkOutput("flush_ready", {31'd0, bus.alu_to_rs_ready}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #1;
            if (bus.alu_to_rs_ready === 1'b1) pulses++;
        end
        checkOutput("flush_no_result", pulses, 32'd0);

        applyStimulus(6'd51, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'h900, 4'd9);
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b1;
        waitResult(cycles, busy_cycles);
        checkOutput("stall_latency", cycles + 15, 32'd37);
        checkResult("mulhu_stall", 32'd1, 4'd9, 1'b0, 32'h904);
`else
        applyStimulus(6'd49, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'h500, 4'd5);
        checkOutput("mulh_disabled_busy", {31'd0, bus.alu_busy}, 32'd0);
        checkResult("mulh_disabled", 32'd0, 4'd5, 1'b0, 32'h504);
        applyStimulus(6'd48, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'h600, 4'd6);
        checkResult("mul_disabled", 32'd0, 4'd6, 1'b0, 32'h604);

        @(negedge clk_in);
        clr_in = 1'b1;
        bus.rs_to_alu_ready = 1'b1;
        bus.rs_to_alu_op    = 6'd0;
        @(posedge clk_in);
        #1;
        clr_in = 1'b0;
        bus.rs_to_alu_ready = 1'b0;
        checkOutput("flush_drops_dispatch", {31'd0, bus.alu_to_rs_ready}, 32'd0);

        applyStimulus(6'd8, 32'hF0, 32'h0F, 32'd0, 32'h900, 4'd9);
        @(negedge clk_in);
        rdy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("stall_holds_ready", {31'd0, bus.alu_to_rs_ready}, 32'd1);
        checkOutput("stall_holds_result", bus.alu_to_rs_result, 32'hFF);
        @(negedge clk_in);
        rdy_in = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/execute_alu.md
# execute_alu

Execution unit on the consumer side of the reservation station dispatch interface. It accepts one ready instruction per cycle, computes the integer or branch result, and broadcasts the result with its ROB index back to the RS/ROB bus. An optional iterative multiplier is included, with a busy handshake that back-pressures dispatch.

## Interface
Parameters:
- DATA_W, 32, operand/result width (fixed 32; `DATA_TYPE`)
- ROB_W, 4, ROB index width (`ROB_INDEX_TYPE`); index 0 never dispatched
- OP_W, 6, op encoding width (`OPENUM_TYPE`)

Ports (one clock; reset is asynchronous and active-low):
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; low = all state frozen, inputs ignored
- clr_in  in  1  synchronous flush (mispredict)
- rs_to_alu_ready  in  1  dispatch valid, single-cycle pulse
- rs_to_alu_op  in  OP_W  operation
- rs_to_alu_rs1 / rs_to_alu_rs2 / rs_to_alu_imm / rs_to_alu_PC  in  32 each  operands
- rs_to_alu_rob_index  in  ROB_W  destination tag
- alu_busy  out  1  high = next dispatch is not accepted
- alu_to_rs_ready  out  1  result valid, one-cycle pulse
- alu_to_rs_result  out  32  rd value
- alu_to_rs_rob_index  out  ROB_W  tag of the result
- alu_to_rob_jump  out  1  control flow taken
- alu_to_rob_target  out  32  next PC for branch/jump ops

## Operation
- Op codes:
  - 0-9: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND on rs1 and rs2.
  - 16-25: same ALU function selected by bits [3:0], with imm as the second operand. SUB has no immediate form; code 17 is undefined.
  - 32: LUI, result = imm.
  - 33: AUIPC, result = PC+imm.
  - 34: JAL, result = PC+4; target = PC+imm; jump = 1.
  - 35: JALR, result = PC+4; target = (rs1+imm)&~1; jump = 1.
  - 40-45: BEQ, BNE, BLT, BGE, BLTU, BGEU. Result = 0. jump = condition. target = PC+imm if the branch is taken, else PC+4.
  - 48-51: MUL, MULH, MULHSU, MULHU (only under the macro).
  - Any other code: result 0, jump 0, target PC+4.
- Shift amount = second operand [4:0]. Arithmetic is modulo 2^32.
- For non-jump ops, jump = 0 and target = PC+4.
- Multiplier FSM has three states: IDLE, RUN, DONE.
  - IDLE→RUN on accepting a mul op. Latches operand magnitudes and the result sign. Counter = 0.
  - RUN performs one shift-add step per cycle into a 64-bit accumulator. Goes to DONE when counter = 31.
  - DONE negates the product if the sign flag is set, selects the low or high word, pulses the outputs, then returns to IDLE.
  - Sign handling: MULH treats both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU and MUL treat both as unsigned (the low word is sign-independent).
- A dispatch while alu_busy = 1 is dropped. No result is produced (protocol violation; assertion in the bench).
- clr_in = 1: next edge clears alu_to_rs_ready, FSM → IDLE, alu_busy = 0, and any mul in flight is discarded. clr_in takes priority over a same-cycle dispatch.
- rdy_in = 0: every register holds. This includes the FSM, the counter and the output valid.

## Timing
- Reset (rst_in low, asynchronous): all outputs 0, FSM IDLE, counter 0.
- Single-cycle op accepted at edge N: outputs valid in the cycle after N for exactly one cycle.
- Mul op accepted at edge N:
  - alu_busy is high from edge N+1 through edge N+31.
  - alu_to_rs_ready is high in the cycle after edge N+32, with alu_busy low.
  - A dispatch in that same cycle is accepted, so back-to-back operation is possible.
  - Single-cycle results can never collide with the mul result.
- Throughput: 1 op/cycle for single-cycle ops. One mul per 33 cycles.
- Outputs are registered only. There is no combinational path from inputs to outputs.

## Configuration
- ALU_MUL_EN defined:
  - Multiplier FSM and 64-bit accumulator are built.
  - Ops 48-51 behave as above.
  - alu_busy operates as specified.
- ALU_MUL_EN undefined:
  - No FSM and no accumulator are built.
  - Ops 48-51 complete in one cycle as undefined ops (result 0).
  - alu_busy is tied to 0.

## Test plan
- Reset: assert rst_in low mid-mul → all outputs 0 immediately, FSM IDLE; after release, ADD rs1=5, rs2=7, rob=3 → next cycle ready=1, result=12, rob=3.
- Branch: BLT with rs1=0xFFFFFFFF, rs2=1, PC=0x100, imm=0x20 → jump=1, target=0x120, result=0. Same operands with BLTU → jump=0, target=0x104.
- JALR: rs1=0x1001, imm=4, PC=0x200 → result=0x204, target=0x1004, jump=1.
- Multiply (ALU_MUL_EN): MULH with rs1=0xFFFFFFFE (-2), rs2=3 → busy for 31 cycles, then result 0xFFFFFFFF. Then MUL with the same operands → result 0xFFFFFFFA. Then an ADD dispatched in the result cycle → ADD result in the following cycle.
- Flush: clr_in=1 at cycle 10 of a mul → no alu_to_rs_ready, busy=0 next cycle; a same-cycle dispatch is dropped.
- Stall: rdy_in=0 for 5 cycles during a mul → result delayed by exactly 5 cycles, with an identical value.
